vec_quantizer: RTL and testbench

Multi-channel successor to the scalar post-ReLU quantizer. It takes N_CH wide accumulator words per beat and applies a per-beat right shift, optional round-half-up and signed or unsigned saturation to BW_O bits. It sits between the conv/accumulate stage and the next layer's input buffer in the wrd datapath. A two-stage pipeline with full valid/ready backpressure replaces the old registered-ready scheme. Per-frame saturation statistics are reported for calibration.

---
 rtl/vec_quantizer_pkg.sv | 30 +++
 rtl/vec_quantizer_if.sv | 33 +++
 rtl/vec_quantizer_lane.sv | 89 ++++++++
 rtl/vec_quantizer.sv | 119 +++++++++++
 tb/tb_vec_quantizer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vec_quantizer_pkg.sv
// Shared types and helpers for the multi-channel post-ReLU quantizer.
package wrd_quant_pkg;

    typedef enum logic {
        QUANT_UNSIGNED = 1'b0,
        QUANT_SIGNED   = 1'b1
    } sign_mode_e;

    // Largest code the output can hold; both modes share this ceiling so the
    // unsigned path keeps the saturate point of the scalar quantizer.
    function automatic longint sat_hi(input int bw_o);
        return (longint'(1) << (bw_o - 1)) - 1;
    endfunction

    // Smallest code the output may take for the given sign mode.
    function automatic longint sat_lo(input int bw_o, input sign_mode_e mode);
        return (mode == QUANT_SIGNED) ? -(longint'(1) << (bw_o - 1)) : longint'(0);
    endfunction

    // Number of set bits, used to total per-channel clamp flags.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/vec_quantizer_if.sv
// Beat stream into and out of the quantizer, including the per-beat mode bits.
interface vec_quantizer_if #(
    parameter int BW_I     = 32,
    parameter int BW_O     = 8,
    parameter int N_CH     = 8,
    parameter int SHIFT_BW = $clog2(BW_I)
) ();

    logic [SHIFT_BW-1:0]    shift_i;
    logic                   signed_i;
    logic                   round_i;
    logic [N_CH*BW_I-1:0]   data_i;
    logic                   valid_i;
    logic                   last_i;
    logic                   ready_o;
    logic [N_CH*BW_O-1:0]   data_o;
    logic                   valid_o;
    logic                   last_o;
    logic                   ready_i;

    // Environment side: produces input beats and consumes output beats.
    modport master (
        output shift_i, signed_i, round_i, data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, last_o
    );

    // Quantizer side.
    modport slave (
        input  shift_i, signed_i, round_i, data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, last_o
    );

endinterface

// File: rtl/vec_quantizer_lane.sv
// One channel of the quantizer: shift/round in stage 1, saturate in stage 2.
// Valid tracking lives in the top; this lane only holds data.
module quant_lane
    import wrd_quant_pkg::*;
#(
    parameter int BW_I     = 32,
    parameter int BW_O     = 8,
    parameter int SHIFT_BW = $clog2(BW_I)
) (
    input  logic                clk_i,
    input  logic                s1_load,
    input  logic                s2_load,
    input  logic [BW_I-1:0]     din,
    input  logic [SHIFT_BW-1:0] shift,
    input  sign_mode_e          mode,
    input  logic                rnd,
    output logic [BW_O-1:0]     dout,
    output logic                sat
);

    // One guard bit above the input so the rounding add can never wrap.
    localparam int EXT_W = BW_I + 1;
    localparam logic signed [63:0] SAT_HI   = sat_hi(BW_O);
    localparam logic signed [63:0] SAT_LO_S = sat_lo(BW_O, QUANT_SIGNED);
    localparam logic signed [63:0] SAT_LO_U = sat_lo(BW_O, QUANT_UNSIGNED);

    logic [EXT_W-1:0]    ext;
    logic [EXT_W-1:0]    rnd_add;
    logic [EXT_W-1:0]    sum;
    logic [EXT_W-1:0]    shifted;
    logic [EXT_W-1:0]    s1_val;
    sign_mode_e          s1_mode;
    logic signed [63:0]  wide;
    logic signed [63:0]  lo;
    logic [BW_O-1:0]     q_next;
    logic                sat_next;

    // Extend, add the half-LSB when rounding, then shift by the beat's amount.
    always_comb begin
        ext     = (mode == QUANT_SIGNED) ? {din[BW_I-1], din} : {1'b0, din};
        rnd_add = '0;
        if (rnd && (shift != '0)) begin
            rnd_add = EXT_W'(1) << (shift - SHIFT_BW'(1));
        end
        sum = ext + rnd_add;
        if (mode == QUANT_SIGNED) begin
            shifted = $signed(sum) >>> shift;
        end else begin
            shifted = sum >> shift;
        end
    end

    // Stage 1 register; the sign mode rides along for the saturate step.
    always_ff @(posedge clk_i) begin
        if (s1_load) begin
            s1_val  <= shifted;
            s1_mode <= mode;
        end
    end

    // Clamp the shifted value into the output code range and flag clamping.
    always_comb begin
        if (s1_mode == QUANT_SIGNED) begin
            wide = {{(64-EXT_W){s1_val[EXT_W-1]}}, s1_val};
            lo   = SAT_LO_S;
        end else begin
            wide = {{(64-EXT_W){1'b0}}, s1_val};
            lo   = SAT_LO_U;
        end
        q_next   = wide[BW_O-1:0];
        sat_next = 1'b0;
        if (wide > SAT_HI) begin
            q_next   = SAT_HI[BW_O-1:0];
            sat_next = 1'b1;
        end else if (wide < lo) begin
            q_next   = lo[BW_O-1:0];
            sat_next = 1'b1;
        end
    end

    // Stage 2 register feeding the output bus directly.
    always_ff @(posedge clk_i) begin
        if (s2_load) begin
            dout <= q_next;
            sat  <= sat_next;
        end
    end

endmodule

// File: rtl/vec_quantizer.sv
// Multi-channel quantizer top: two-stage valid/ready pipeline around N_CH
// lanes, plus a per-frame count of clamped channel-samples.
module vec_quantizer
    import wrd_quant_pkg::*;
#(
    parameter int BW_I     = 32,
    parameter int BW_O     = 8,
    parameter int N_CH     = 8,
    parameter int SHIFT_BW = $clog2(BW_I),
    parameter int CNT_BW   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    vec_quantizer_if.slave    bus,
    output logic [CNT_BW-1:0] frame_sat_o,
    output logic              frame_sat_valid_o
);

    localparam int PC_BW = $clog2(N_CH + 1);

    logic                  s1_valid;
    logic                  s2_valid;
    logic                  s1_last;
    logic                  s2_last;
    logic                  s1_adv;
    logic                  s2_adv;
    logic                  out_fire;
    logic [N_CH-1:0]       sat_flags;
    logic [N_CH*BW_O-1:0]  data_q;
    logic [PC_BW-1:0]      pc;
    logic [CNT_BW:0]       sum;
    logic [CNT_BW-1:0]     sat_sum;
    logic [CNT_BW-1:0]     run_cnt;
    logic [CNT_BW-1:0]     frame_sat_q;
    logic                  pulse_q;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        s2_adv   = !s2_valid || bus.ready_i;
        s1_adv   = !s1_valid || s2_adv;
        out_fire = s2_valid && bus.ready_i;
    end

    assign bus.ready_o         = s1_adv;
    assign bus.valid_o         = s2_valid;
    assign bus.last_o          = s2_valid && s2_last;
    assign bus.data_o          = data_q;
    assign frame_sat_o         = frame_sat_q;
    assign frame_sat_valid_o   = pulse_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        quant_lane #(
            .BW_I     (BW_I),
            .BW_O     (BW_O),
            .SHIFT_BW (SHIFT_BW)
        ) u_lane (
            .clk_i   (clk_i),
            .s1_load (s1_adv && bus.valid_i),
            .s2_load (s2_adv && s1_valid),
            .din     (bus.data_i[c*BW_I +: BW_I]),
            .shift   (bus.shift_i),
            .mode    (sign_mode_e'(bus.signed_i)),
            .rnd     (bus.round_i),
            .dout    (data_q[c*BW_O +: BW_O]),
            .sat     (sat_flags[c])
        );
    end

    // Stage valid and frame-end tracking; reset discards whatever is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.valid_i;
                if (bus.valid_i) begin
                    s1_last <= bus.last_i;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_last <= s1_last;
                end
            end
        end
    end

    // Running total plus this beat's clamp count, pinned at the counter ceiling.
    always_comb begin
        pc      = PC_BW'(popcount(64'(sat_flags)));
        sum     = {1'b0, run_cnt} + (CNT_BW+1)'(pc);
        sat_sum = sum[CNT_BW] ? '1 : sum[CNT_BW-1:0];
    end

    // Accumulate per output beat; publish and clear at the frame's last beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cnt     <= '0;
            frame_sat_q <= '0;
            pulse_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (out_fire) begin
                if (s2_last) begin
                    frame_sat_q <= sat_sum;
                    pulse_q     <= 1'b1;
                    run_cnt     <= '0;
                end else begin
                    run_cnt <= sat_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_quantizer.sv
// Bench for vec_quantizer: directed and random beats scored against an
// arithmetic reference model, with a queue standing in for the pipeline.
module tb_vec_quantizer;

    localparam int BW_I     = 32;
    localparam int BW_O     = 8;
    localparam int N_CH     = 8;
    localparam int SHIFT_BW = 5;
    localparam int CNT_BW   = 16;
    localparam int CNT_MAX  = (1 << CNT_BW) - 1;

    typedef struct {
        logic [N_CH*BW_I-1:0] data;
        logic [SHIFT_BW-1:0]  shift;
        bit                   sg;
        bit                   rd;
        bit                   last;
    } beat_t;

    typedef struct {
        logic [N_CH*BW_O-1:0] data;
        bit                   last;
        int                   pc;
        int                   age;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [CNT_BW-1:0] frame_sat_o;
    logic              frame_sat_valid_o;

    vec_quantizer_if #(.BW_I(BW_I), .BW_O(BW_O), .N_CH(N_CH), .SHIFT_BW(SHIFT_BW)) bus ();

    vec_quantizer #(
        .BW_I(BW_I), .BW_O(BW_O), .N_CH(N_CH), .SHIFT_BW(SHIFT_BW), .CNT_BW(CNT_BW)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .bus               (bus.slave),
        .frame_sat_o       (frame_sat_o),
        .frame_sat_valid_o (frame_sat_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int                   checks = 0;
    int                   failures = 0;
    beat_t                stimQ[$];
    exp_t                 expQ[$];
    logic [N_CH*BW_O-1:0] obsOut[$];
    logic [CNT_BW-1:0]    obsPulse[$];
    beat_t                curBeat;
    int                   run = 0;
    bit                   expPulse = 0;
    int                   expFrameSat = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Quantize one channel with plain integer arithmetic.
    function automatic logic [BW_O-1:0] refChan(input logic [BW_I-1:0] x, input int sh,
                                                 input bit sg, input bit rd, output bit sat);
        longint v, hi, lo;
        v = sg ? longint'($signed(x)) : longint'(x);
        if (rd && sh > 0) v = v + (longint'(1) << (sh - 1));
        v  = v >>> sh;
        hi = (longint'(1) << (BW_O - 1)) - 1;
        lo = sg ? -(hi + 1) : longint'(0);
        sat = 0;
        if (v > hi) begin v = hi; sat = 1; end
        else if (v < lo) begin v = lo; sat = 1; end
        return v[BW_O-1:0];
    endfunction

    function automatic exp_t model(input beat_t b);
        exp_t e;
        bit   s;
        e.pc = 0;
        e.age = 0;
        e.last = b.last;
        e.data = '0;
        for (int c = 0; c < N_CH; c++) begin
            e.data[c*BW_O +: BW_O] = refChan(b.data[c*BW_I +: BW_I], int'(b.shift), b.sg, b.rd, s);
            e.pc += int'(s);
        end
        return e;
    endfunction

    function automatic beat_t mkBeat(input logic [N_CH*BW_I-1:0] d, input int sh,
                                     input bit sg, input bit rd, input bit last);
        beat_t b;
        b.data = d; b.shift = SHIFT_BW'(sh); b.sg = sg; b.rd = rd; b.last = last;
        return b;
    endfunction

    function automatic logic [BW_I-1:0] randWord();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return BW_I'($urandom_range(0, 511)) - BW_I'(256);
            2: return $urandom_range(0, 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
            default: return BW_I'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic bit readyFor(input int mode, input int cyc);
        case (mode)
            0: return 1'b1;
            1: return (cyc % 3) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    function automatic logic [CNT_BW-1:0] lastPulse();
        if (obsPulse.size() > 0) return obsPulse[obsPulse.size()-1];
        return 'x;
    endfunction

    // Compare outputs with the model, then advance the model across the next edge.
    task automatic checkOutput(output bit inFire);
        bit   expRdy, expValid;
        exp_t e;
        expRdy   = !(expQ.size() == 2 && !bus.ready_i);
        expValid = expQ.size() > 0 && expQ[0].age >= 2;
        chk("ready_o", 64'(bus.ready_o), 64'(expRdy));
        chk("valid_o", 64'(bus.valid_o), 64'(expValid));
        if (expValid) begin
            chk("data_o", 64'(bus.data_o), 64'(expQ[0].data));
            chk("last_o", 64'(bus.last_o), 64'(expQ[0].last));
        end
        chk("frame_sat_valid_o", 64'(frame_sat_valid_o), 64'(expPulse));
        chk("frame_sat_o", 64'(frame_sat_o), 64'(expFrameSat));
        if (frame_sat_valid_o === 1'b1) obsPulse.push_back(frame_sat_o);
        inFire = 0;
        if (rst_i) begin
            expQ.delete();
            run = 0;
            expPulse = 0;
            expFrameSat = 0;
        end else begin
            expPulse = 0;
            if (expValid && bus.ready_i) begin
                obsOut.push_back(bus.data_o);
                e = expQ.pop_front();
                run += e.pc;
                if (run > CNT_MAX) run = CNT_MAX;
                if (e.last) begin
                    expPulse = 1;
                    expFrameSat = run;
                    run = 0;
                end
            end
            inFire = bus.valid_i && bus.ready_o;
            if (inFire) expQ.push_back(model(curBeat));
            foreach (expQ[i]) expQ[i].age++;
        end
    endtask

    task automatic applyStimulus(input bit v, input beat_t b, input bit rdy, input bit rst,
                                 output bit fired);
        curBeat      = b;
        bus.valid_i  = v;
        bus.data_i   = b.data;
        bus.shift_i  = b.shift;
        bus.signed_i = b.sg;
        bus.round_i  = b.rd;
        bus.last_i   = b.last;
        bus.ready_i  = rdy;
        rst_i        = rst;
        @(negedge clk_i);
        checkOutput(fired);
        @(posedge clk_i);
        #1;
    endtask

    // Drive queued beats until everything has drained and any pulse was seen.
    task automatic pump(input int rdyMode, input int budget);
        int    cyc;
        bit    v, fired;
        beat_t b;
        cyc = 0;
        while ((stimQ.size() > 0 || expQ.size() > 0 || expPulse) && cyc < budget) begin
            v = stimQ.size() > 0;
            b = v ? stimQ[0] : mkBeat('0, 0, 0, 0, 0);
            applyStimulus(v, b, readyFor(rdyMode, cyc), 1'b0, fired);
            if (fired) void'(stimQ.pop_front());
            cyc++;
        end
        if (cyc >= budget) begin
            checks++;
            failures++;
            $error("[TB] FAIL pump_timeout observed=%0d expected<%0d", cyc, budget);
            stimQ.delete();
        end
    endtask

    logic [N_CH*BW_I-1:0] d;
    logic [N_CH*BW_O-1:0] o;
    beat_t                bb;
    bit                   fired;
    int                   accepted;

    initial begin
        bb = mkBeat('0, 0, 0, 0, 0);
        bus.valid_i = 0; bus.ready_i = 0; bus.data_i = '0; bus.shift_i = '0;
        bus.signed_i = 0; bus.round_i = 0; bus.last_i = 0; curBeat = bb;
        rst_i = 1;
        repeat (3) @(posedge clk_i);
        #1;
        $display("[TB] reset state");
        applyStimulus(0, bb, 1, 0, fired);
        chk("reset_last_o", 64'(bus.last_o), 64'(0));

        $display("[TB] unsigned shift 4");
        obsOut.delete(); obsPulse.delete();
        d = '0; d[0 +: 32] = 32'h0000_07F0; d[32 +: 32] = 32'h0000_0800;
        stimQ.push_back(mkBeat(d, 4, 0, 0, 1));
        pump(0, 50);
        o = obsOut.size() > 0 ? obsOut[0] : 'x;
        chk("t1_ch0", 64'(o[7:0]), 64'h7F);
        chk("t1_ch1", 64'(o[15:8]), 64'h7F);
        chk("t1_pulse", 64'(lastPulse()), 64'd1);

        $display("[TB] signed shift 2 round");
        obsOut.delete(); obsPulse.delete();
        d = '0; d[0 +: 32] = 32'hFFFF_FFFA; d[32 +: 32] = 32'd5; d[64 +: 32] = 32'h8000_0000;
        stimQ.push_back(mkBeat(d, 2, 1, 1, 1));
        pump(0, 50);
        o = obsOut.size() > 0 ? obsOut[0] : 'x;
        chk("t2_ch0", 64'(o[7:0]), 64'hFF);
        chk("t2_ch1", 64'(o[15:8]), 64'h01);
        chk("t2_ch2", 64'(o[23:16]), 64'h80);
        chk("t2_pulse", 64'(lastPulse()), 64'd1);

        $display("[TB] rounding carry and shift boundaries");
        obsOut.delete(); obsPulse.delete();
        d = '0; d[0 +: 32] = 32'hFFFF_FFFF;
        stimQ.push_back(mkBeat(d, 1, 0, 1, 0));
        d = '0; d[0 +: 32] = 32'h8000_0000; d[32 +: 32] = 32'h4000_0000;
        stimQ.push_back(mkBeat(d, BW_I - 1, 1, 1, 0));
        d = '0; d[0 +: 32] = 32'h0000_007E;
        stimQ.push_back(mkBeat(d, 0, 0, 1, 1));
        pump(0, 50);
        o = obsOut.size() > 0 ? obsOut[0] : 'x;
        chk("t3_carry", 64'(o[7:0]), 64'h7F);
        o = obsOut.size() > 1 ? obsOut[1] : 'x;
        chk("t3_sh31_ch0", 64'(o[7:0]), 64'hFF);
        chk("t3_sh31_ch1", 64'(o[15:8]), 64'h01);
        o = obsOut.size() > 2 ? obsOut[2] : 'x;
        chk("t3_sh0", 64'(o[7:0]), 64'h7E);
        chk("t3_pulse", 64'(lastPulse()), 64'd1);

        $display("[TB] backpressure 1,0,0");
        obsOut.delete(); obsPulse.delete();
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < N_CH; c++) d[c*BW_I +: BW_I] = randWord();
            stimQ.push_back(mkBeat(d, $urandom_range(0, 31), 1'($urandom), 1'($urandom), i == 9));
        end
        pump(1, 200);
        chk("bp_count", 64'(obsOut.size()), 64'd10);

        $display("[TB] frame stats A=3 B=0, back-to-back lasts");
        obsOut.delete(); obsPulse.delete();
        d = '0; d[0 +: 32] = 32'h800; d[32 +: 32] = 32'h800;
        stimQ.push_back(mkBeat(d, 4, 0, 0, 0));
        d = '0; d[0 +: 32] = 32'h1000; d[32 +: 32] = 32'h10;
        stimQ.push_back(mkBeat(d, 4, 0, 0, 1));
        d = '0; d[0 +: 32] = 32'h10;
        stimQ.push_back(mkBeat(d, 4, 0, 0, 1));
        pump(0, 50);
        chk("stats_pulses", 64'(obsPulse.size()), 64'd2);
        chk("stats_A", 64'(obsPulse.size() > 0 ? obsPulse[0] : 'x), 64'd3);
        chk("stats_B", 64'(lastPulse()), 64'd0);

        $display("[TB] counter ceiling");
        obsOut.delete(); obsPulse.delete();
        d = '1;
        for (int i = 0; i < (1 << 13); i++) stimQ.push_back(mkBeat(d, 0, 0, 0, i == (1 << 13) - 1));
        pump(0, 9000);
        chk("stats_ceiling", 64'(lastPulse()), 64'hFFFF);

        $display("[TB] random stream");
        obsOut.delete(); obsPulse.delete();
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N_CH; c++) d[c*BW_I +: BW_I] = randWord();
            stimQ.push_back(mkBeat(d, $urandom_range(0, 31), 1'($urandom), 1'($urandom),
                                   ($urandom_range(0, 4) == 0) || i == 299));
        end
        pump(2, 3000);
        chk("rand_count", 64'(obsOut.size()), 64'd300);

        $display("[TB] reset mid-frame");
        obsOut.delete(); obsPulse.delete();
        d = '1;
        stimQ.push_back(mkBeat(d, 0, 0, 0, 0));
        stimQ.push_back(mkBeat(d, 0, 0, 0, 0));
        pump(0, 50);
        accepted = 0;
        for (int i = 0; i < 10 && accepted < 2; i++) begin
            applyStimulus(1, mkBeat(d, 0, 0, 0, 0), 0, 0, fired);
            if (fired) accepted++;
        end
        chk("rst_fill", 64'(accepted), 64'd2);
        chk("rst_stalled_ready", 64'(bus.ready_o), 64'd0);
        applyStimulus(0, bb, 0, 1, fired);
        applyStimulus(0, bb, 1, 0, fired);
        chk("rst_no_pulse", 64'(obsPulse.size()), 64'd0);
        d = '0; d[0 +: 32] = 32'hFFFF_FFFF;
        stimQ.push_back(mkBeat(d, 0, 0, 0, 1));
        pump(0, 50);
        chk("rst_fresh_count", 64'(lastPulse()), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
